// File: rtl/seq_shifter.sv
// Multi-cycle variable-amount shifter (0-15 places, one bit per clock).
// Captures operands on an accepted start and reports result plus last bit shifted out.
module seq_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] in,
  input  logic [1:0]  shift,
  input  logic [3:0]  amt,
  output logic        busy,
  output logic        done,
  output logic [15:0] sout,
  output logic        cout
);

  localparam int unsigned W  = 16;
  localparam int unsigned AW = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_LSL  = 2'b01;
  localparam logic [1:0] OP_LSR  = 2'b10;
  localparam logic [1:0] OP_ASR  = 2'b11;

  logic [1:0]    state, state_nxt;
  logic [1:0]    op, op_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [W-1:0]  sout_nxt;
  logic          cout_nxt;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      op    <= OP_NONE;
      cnt   <= '0;
      sout  <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      op    <= op_nxt;
      cnt   <= cnt_nxt;
      sout  <= sout_nxt;
      cout  <= cout_nxt;
      busy  <= (state_nxt != S_IDLE);
      done  <= (state_nxt == S_DONE);
    end
  end

  // Next-state and datapath step
  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    cnt_nxt   = cnt;
    sout_nxt  = sout;
    cout_nxt  = cout;

    case (state)
      S_IDLE: begin
        if (start) begin
          sout_nxt = in;
          op_nxt   = shift;
          cout_nxt = 1'b0;
          cnt_nxt  = (shift == OP_NONE) ? AW'(0) : amt;
          state_nxt = ((shift == OP_NONE) || (amt == AW'(0))) ? S_DONE : S_SHIFT;
        end
      end

      S_SHIFT: begin
        case (op)
          OP_LSL: begin
            sout_nxt = {sout[W-2:0], 1'b0};
            cout_nxt = sout[W-1];
          end
          OP_LSR: begin
            sout_nxt = {1'b0, sout[W-1:1]};
            cout_nxt = sout[0];
          end
          OP_ASR: begin
            sout_nxt = {sout[W-1], sout[W-1:1]};
            cout_nxt = sout[0];
          end
          default: begin
            sout_nxt = sout;
            cout_nxt = cout;
          end
        endcase
        cnt_nxt = cnt - AW'(1);
        if (cnt == AW'(1)) state_nxt = S_DONE;
      end

      S_DONE:  state_nxt = S_IDLE;

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed, table-driven bench for seq_shifter with hand-written multi-cycle corner cases.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] in;
  logic [1:0]  shift;
  logic [3:0]  amt;
  logic        busy, done, cout;
  logic [15:0] sout;

  int errors = 0;
  int checks = 0;

  seq_shifter dut (
    .clk(clk), .reset(reset), .start(start), .in(in), .shift(shift), .amt(amt),
    .busy(busy), .done(done), .sout(sout), .cout(cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] in;
    logic [1:0]  shift;
    logic [3:0]  amt;
    logic [15:0] exp_sout;
    logic        exp_cout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait for done (bounded) after the acceptance edge; returns edges counted past it
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [15:0] i, input logic [1:0] s,
                        input logic [3:0] a, input logic [15:0] es, input logic ec);
    int n;
    int eff;
    eff = (s == 2'b00) ? 0 : int'(a);
    @(negedge clk);
    in = i; shift = s; amt = a; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in = 16'hDEAD; shift = 2'b01; amt = 4'd7;
    wait_done(n);
    chk({name, " latency"}, 32'(n), 32'(eff));
    chk({name, " busy@done"}, 32'(busy), 32'd1);
    chk({name, " sout"}, 32'(sout), 32'(es));
    chk({name, " cout"}, 32'(cout), 32'(ec));
    @(posedge clk); #1;
    chk({name, " done clears"}, 32'(done), 32'd0);
    chk({name, " busy clears"}, 32'(busy), 32'd0);
    chk({name, " sout holds"}, 32'(sout), 32'(es));
  endtask

  vec_t vecs[11];
  int   n;

  initial begin
    vecs[0]  = '{16'h0001, 2'b01, 4'd15, 16'h8000, 1'b0};
    vecs[1]  = '{16'h8001, 2'b01, 4'd1,  16'h0002, 1'b1};
    vecs[2]  = '{16'h8001, 2'b10, 4'd1,  16'h4000, 1'b1};
    vecs[3]  = '{16'h8000, 2'b11, 4'd4,  16'hF800, 1'b0};
    vecs[4]  = '{16'h7FF0, 2'b11, 4'd5,  16'h03FF, 1'b1};
    vecs[5]  = '{16'hBEEF, 2'b01, 4'd0,  16'hBEEF, 1'b0};
    vecs[6]  = '{16'hBEEF, 2'b00, 4'd9,  16'hBEEF, 1'b0};
    vecs[7]  = '{16'hF000, 2'b10, 4'd8,  16'h00F0, 1'b0};
    vecs[8]  = '{16'h0003, 2'b01, 4'd2,  16'h000C, 1'b0};
    vecs[9]  = '{16'hA5A5, 2'b11, 4'd15, 16'hFFFF, 1'b0};
    vecs[10] = '{16'hA5A5, 2'b10, 4'd3,  16'h14B4, 1'b1};

    reset = 1'b1; start = 1'b0; in = '0; shift = '0; amt = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset sout", 32'(sout), 32'd0);
    chk("reset cout", 32'(cout), 32'd0);
    @(negedge clk); reset = 1'b0;

    for (int k = 0; k < 11; k++)
      run_op($sformatf("vec%0d", k), vecs[k].in, vecs[k].shift, vecs[k].amt,
             vecs[k].exp_sout, vecs[k].exp_cout);

    // Start pulsed while busy must be ignored
    @(negedge clk);
    in = 16'hF000; shift = 2'b10; amt = 4'd8; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    in = 16'h1234; shift = 2'b01; amt = 4'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 3;
    while (done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    chk("ignore latency", 32'(n), 32'd8);
    chk("ignore sout", 32'(sout), 32'h00F0);
    chk("ignore cout", 32'(cout), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("ignore idle busy", 32'(busy), 32'd0);
    chk("ignore idle sout", 32'(sout), 32'h00F0);

    // Reset mid-shift abandons the operation
    @(negedge clk);
    in = 16'h00FF; shift = 2'b01; amt = 4'd10; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst sout", 32'(sout), 32'd0);
    chk("midrst cout", 32'(cout), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    @(negedge clk); reset = 1'b0;
    n = 0;
    repeat (12) begin @(posedge clk); #1; if (done === 1'b1) n++; end
    chk("midrst no done", 32'(n), 32'd0);
    run_op("post-reset", 16'h0003, 2'b01, 4'd2, 16'h000C, 1'b0);

    // Back-to-back with start held high
    @(negedge clk);
    in = 16'h0001; shift = 2'b01; amt = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    wait_done(n);
    chk("b2b first latency", 32'(n), 32'd2);
    chk("b2b first sout", 32'(sout), 32'h0004);
    in = 16'h0F08; shift = 2'b10; amt = 4'd4;
    @(posedge clk); #1;
    chk("b2b idle busy", 32'(busy), 32'd0);
    chk("b2b idle done", 32'(done), 32'd0);
    chk("b2b idle sout", 32'(sout), 32'h0004);
    chk("b2b idle cout", 32'(cout), 32'd0);
    @(posedge clk); #1;
    chk("b2b second accepted", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(n);
    chk("b2b second latency", 32'(n), 32'd4);
    chk("b2b second sout", 32'(sout), 32'h00F0);
    chk("b2b second cout", 32'(cout), 32'd1);

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
